puf_helper_gen: RTL



---
 rtl/puf_helper_gen_if.sv | 25 ++
 rtl/puf_helper_gen.sv | 124 ++++++++++++
 2 files changed

// File: rtl/puf_helper_gen_if.sv
// Go/Done handshake and data bundle for the PUF helper-data generator.
// The controller drives the master side; puf_helper_gen takes the slave side.
interface puf_helper_gen_if;
    logic         Enc_Go;
    logic [255:0] data_in;
    logic         Enc_Busy;
    logic         Enc_Done;
    logic [0:95]  o_helper;

    modport master (
        output Enc_Go,
        output data_in,
        input  Enc_Busy,
        input  Enc_Done,
        input  o_helper
    );

    modport slave (
        input  Enc_Go,
        input  data_in,
        output Enc_Busy,
        output Enc_Done,
        output o_helper
    );
endinterface

// File: rtl/puf_helper_gen.sv
// Enrollment helper generator: 12-bit CRC remainder per 32-bit response chunk.
// Optional macro HELPER_RESTART_EN: Enc_Go during SHIFT aborts and restarts.
module puf_helper_gen #(
    parameter int          BITS_PER_CYCLE = 1,
    parameter logic [11:0] POLY           = 12'h80F
) (
    input logic              clk,
    input logic              Resetn,
    puf_helper_gen_if.slave  bus
);

    localparam logic [4:0] LAST_BEAT = 5'(32 / BITS_PER_CYCLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [255:0]  r_sr;
    logic [11:0]   r_rem;
    logic [2:0]    r_chunk;
    logic [4:0]    r_bitcnt;
    logic [0:95]   r_work;
    logic [0:95]   r_helper;
    logic [11:0]   w_rem_step;
    logic          w_last_beat;
    logic          w_last_chunk;
    logic          w_restart;
    logic          w_load;

    assign w_last_beat  = (r_bitcnt == LAST_BEAT);
    assign w_last_chunk = (r_chunk == 3'd7);

`ifdef HELPER_RESTART_EN
    assign w_restart = (r_state == S_SHIFT) && bus.Enc_Go;
`else
    assign w_restart = 1'b0;
`endif

    assign w_load = ((r_state == S_IDLE) && bus.Enc_Go) || w_restart;

    assign bus.Enc_Busy = (r_state != S_IDLE);
    assign bus.Enc_Done = (r_state == S_DONE);
    assign bus.o_helper = r_helper;

    // Unrolled LFSR divider: consume BITS_PER_CYCLE chunk bits, MSB first.
    always_comb begin
        w_rem_step = r_rem;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            w_rem_step = {w_rem_step[10:0], 1'b0}
                       ^ ((r_sr[31-j] ^ w_rem_step[11]) ? POLY : 12'h0);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> SHIFT -> DONE -> IDLE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.Enc_Go) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_restart) begin
                    w_state_next = S_SHIFT;
                end else if (w_last_beat && w_last_chunk) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: shift the response, collect slots, publish all 96 bits at once.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            r_sr     <= '0;
            r_rem    <= '0;
            r_chunk  <= '0;
            r_bitcnt <= '0;
            r_work   <= '0;
            r_helper <= '0;
        end else if (w_load) begin
            r_sr     <= bus.data_in;
            r_rem    <= '0;
            r_chunk  <= '0;
            r_bitcnt <= '0;
        end else if (r_state == S_SHIFT) begin
            if (w_last_beat) begin
                r_work[12*int'(r_chunk) +: 12] <= w_rem_step;
                r_rem    <= '0;
                r_chunk  <= r_chunk + 3'd1;
                r_bitcnt <= '0;
                r_sr     <= r_sr >> 32;
                if (w_last_chunk) begin
                    r_helper <= {r_work[0:83], w_rem_step};
                end
            end else begin
                r_rem    <= w_rem_step;
                r_bitcnt <= r_bitcnt + 5'd1;
                r_sr     <= {r_sr[255:32], r_sr[31:0] << BITS_PER_CYCLE};
            end
        end
    end

endmodule
